// File: rtl/spi_pkg.sv
// Shared opcodes, counter widths and state encoding for the SPI RDID responder.
package spi_pkg;

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int unsigned CMD_BITS = 8;
    localparam int unsigned ID_BITS  = 24;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RESP,
        RESP_SR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Pin synchronizer with registered rise/fall pulses; level_o is aligned with the pulses.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    // Chain resets low so a CS_N held low across reset never looks like a new frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign level_o = hist_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_rdid_slave.sv
// SPI mode-0 responder returning a JEDEC ID for RDID, oversampled in the clk domain.
// Optional RDSR status readback is enabled by defining SPI_RDID_SLAVE_STATUS_EN.
module spi_rdid_slave
    import spi_pkg::*;
#(
    parameter logic [7:0]  CMD_RDID    = OP_RDID,
    parameter logic [7:0]  ID_BYTE0    = 8'h20,
    parameter logic [7:0]  ID_BYTE1    = 8'h20,
    parameter logic [7:0]  ID_BYTE2    = 8'h15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       SPICS_N,
`ifdef SPI_RDID_SLAVE_STATUS_EN
    input  logic [7:0] status_in,
`endif
    output logic       SPIMISO,
    output logic       miso_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       busy
);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin_i(SPICLK),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin_i(SPIMOSI),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .pin_i(SPICS_N),
        .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             miso_q, miso_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
`ifdef SPI_RDID_SLAVE_STATUS_EN
    logic [7:0]       status_q, status_d;
`endif

    logic [ID_BITS-1:0] id_word;
    logic [CNT_W-1:0]   id_idx;

    assign id_word = {ID_BYTE0, ID_BYTE1, ID_BYTE2};
    assign id_idx  = CNT_W'(ID_BITS - 1) - cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_RDID_SLAVE_STATUS_EN
            status_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
`ifdef SPI_RDID_SLAVE_STATUS_EN
            status_q    <= status_d;
`endif
        end
    end

    // CS_N rising edge overrides any SPICLK edge seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        miso_d      = miso_q;
`ifdef SPI_RDID_SLAVE_STATUS_EN
        status_d    = status_q;
`endif
        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[6:0], mosi_lvl};
                        if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            cnt_d       = '0;
                            cmd_byte_d  = shift_d;
                            cmd_valid_d = 1'b1;
                            if (shift_d == CMD_RDID) begin
                                state_d = RESP;
                            end
`ifdef SPI_RDID_SLAVE_STATUS_EN
                            else if (shift_d == OP_RDSR) begin
                                state_d  = RESP_SR;
                                status_d = status_in;
                            end
`endif
                            else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (sclk_fall) begin
                        miso_d = id_word[id_idx];
                        cnt_d  = (cnt_q == CNT_W'(ID_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
`ifdef SPI_RDID_SLAVE_STATUS_EN
                RESP_SR: begin
                    if (sclk_fall) begin
                        miso_d = status_q[3'(CMD_BITS - 1) - cnt_q[2:0]];
                        cnt_d  = (cnt_q == CNT_W'(CMD_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
        oe_d = (state_d == RESP) || (state_d == RESP_SR);
        if (!oe_d) begin
            miso_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    assign SPIMISO   = miso_q;
    assign miso_oe   = oe_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_rdid_slave.sv
// Self-checking bench for spi_rdid_slave: directed frame table, hand sequences and random frames.
module tb_spi_rdid_slave;

    localparam int HP = 8;
`ifdef SPI_RDID_SLAVE_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       SPICS_N;
    logic       SPIMISO;
    logic       miso_oe;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       busy;
`ifdef SPI_RDID_SLAVE_STATUS_EN
    logic [7:0] status_in = 8'h00;
`endif

    int errors = 0;
    int checks = 0;
    int cv_count = 0;
    int leak_count = 0;

    logic       rx[$];
    int         oe_hi;
    logic       busy_mid;
    logic [7:0] last_byte = 8'h00;

    always #5 clk = ~clk;

    spi_rdid_slave dut (
        .clk(clk),
        .reset(reset),
        .SPICLK(SPICLK),
        .SPIMOSI(SPIMOSI),
        .SPICS_N(SPICS_N),
`ifdef SPI_RDID_SLAVE_STATUS_EN
        .status_in(status_in),
`endif
        .SPIMISO(SPIMISO),
        .miso_oe(miso_oe),
        .cmd_valid(cmd_valid),
        .cmd_byte(cmd_byte),
        .busy(busy)
    );

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cv_count++;
        if (SPIMISO === 1'b1 && miso_oe !== 1'b1) leak_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI mode-0 bit: master samples MISO at the SPICLK rising edge.
    task automatic spi_bit(input logic mo, output logic mi, output logic oe);
        SPIMOSI = mo;
        wait_clk(HP);
        SPICLK = 1'b1;
        mi = SPIMISO;
        oe = miso_oe;
        wait_clk(HP);
        SPICLK = 1'b0;
    endtask

    // Reference: what the responder should shift out for response bit i of a frame.
    function automatic logic model_bit(input logic [7:0] cmd, input int i, input logic [7:0] st);
        logic [7:0] ids [3];
        logic [7:0] b;
        ids = '{8'h20, 8'h20, 8'h15};
        if (cmd == 8'h9F) begin
            b = ids[(i / 8) % 3];
            return b[7 - (i % 8)];
        end
        if (STATUS_EN && cmd == 8'h05) return st[7 - (i % 8)];
        return 1'b0;
    endfunction

    function automatic logic talks(input logic [7:0] cmd);
        return (cmd == 8'h9F) || (STATUS_EN && cmd == 8'h05);
    endfunction

    task automatic run_frame(input logic [7:0] cmd, input int ncmd, input int nresp);
        logic mi, oe;
        rx.delete();
        oe_hi = 0;
        SPICS_N = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < ncmd; i++) spi_bit(cmd[7 - i], mi, oe);
        busy_mid = busy;
        for (int i = 0; i < nresp; i++) begin
            spi_bit(1'($urandom_range(0, 1)), mi, oe);
            rx.push_back(mi);
            if (oe === 1'b1) oe_hi++;
        end
        wait_clk(HP);
        SPICS_N = 1'b1;
        wait_clk(3 * HP);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input int ncmd, input int nresp,
                            input logic [7:0] st, input int exp_cv, input logic [7:0] exp_byte,
                            input logic exp_oe);
        int         cv_before;
        logic [63:0] act_w, exp_w;
`ifdef SPI_RDID_SLAVE_STATUS_EN
        status_in = st;
`endif
        cv_before = cv_count;
        run_frame(cmd, ncmd, nresp);
        check({tag, " cmd_valid_count"}, 64'(cv_count - cv_before), 64'(exp_cv));
        check({tag, " cmd_byte"}, 64'(cmd_byte), 64'(exp_byte));
        check({tag, " busy_in_frame"}, 64'(busy_mid), 64'd1);
        check({tag, " idle_after"}, {62'd0, busy, miso_oe}, 64'd0);
        check({tag, " miso_leak"}, 64'(leak_count), 64'd0);
        if (nresp > 0) begin
            act_w = '0;
            exp_w = '0;
            for (int i = 0; i < nresp; i++) begin
                act_w = {act_w[62:0], rx[i]};
                exp_w = {exp_w[62:0], exp_oe ? model_bit(cmd, i, st) : 1'b0};
            end
            check({tag, " oe_bits"}, 64'(oe_hi), exp_oe ? 64'(nresp) : 64'd0);
            check({tag, " miso_data"}, act_w, exp_w);
        end
        last_byte = exp_byte;
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         ncmd;
        int         nresp;
        logic [7:0] st;
        int         exp_cv;
        logic [7:0] exp_byte;
        logic       exp_oe;
    } vec_t;

    initial begin
        vec_t vecs [8];
        logic mi, oe;
        logic [7:0] first_byte;
        int mhi, cv_before;

        vecs[0] = '{8'h9F, 8, 24, 8'h00, 1, 8'h9F, 1'b1};
        vecs[1] = '{8'h9F, 8, 48, 8'h00, 1, 8'h9F, 1'b1};
        vecs[2] = '{8'h03, 8, 16, 8'h00, 1, 8'h03, 1'b0};
        vecs[3] = '{8'h9F, 5, 0,  8'h00, 0, 8'h03, 1'b0};
        vecs[4] = '{8'h9F, 8, 24, 8'h00, 1, 8'h9F, 1'b1};
        vecs[5] = '{8'h05, 8, 16, 8'hA5, 1, 8'h05, STATUS_EN};
        vecs[6] = '{8'h00, 8, 8,  8'h00, 1, 8'h00, 1'b0};
        vecs[7] = '{8'h9E, 8, 8,  8'h00, 1, 8'h9E, 1'b0};

        reset   = 1'b1;
        SPICLK  = 1'b0;
        SPIMOSI = 1'b0;
        SPICS_N = 1'b1;
        wait_clk(5);
        check("reset outputs", {59'd0, SPIMISO, miso_oe, cmd_valid, busy, 1'b0}, 64'd0);
        check("reset cmd_byte", 64'(cmd_byte), 64'd0);
        reset = 1'b0;
        wait_clk(4 * HP);

        for (int v = 0; v < 8; v++) begin
            do_frame($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].ncmd, vecs[v].nresp,
                     vecs[v].st, vecs[v].exp_cv, vecs[v].exp_byte, vecs[v].exp_oe);
        end

        // Reset mid-response with CS_N held low: slave must stay silent until a fresh frame.
        SPICS_N = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < 8; i++) spi_bit(vecs[0].cmd[7 - i], mi, oe);
        first_byte = '0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b0, mi, oe);
            first_byte = {first_byte[6:0], mi};
        end
        check("midreset first_byte", 64'(first_byte), 64'h20);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        check("midreset outputs", {60'd0, SPIMISO, miso_oe, busy, 1'b0}, 64'd0);
        check("midreset cmd_byte", 64'(cmd_byte), 64'd0);
        cv_before = cv_count;
        oe_hi = 0;
        mhi = 0;
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'($urandom_range(0, 1)), mi, oe);
            if (oe === 1'b1) oe_hi++;
            if (mi !== 1'b0) mhi++;
        end
        check("midreset oe_silent", 64'(oe_hi), 64'd0);
        check("midreset miso_silent", 64'(mhi), 64'd0);
        check("midreset no_cmd_valid", 64'(cv_count - cv_before), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        wait_clk(HP);
        SPICS_N = 1'b1;
        wait_clk(3 * HP);
        last_byte = 8'h00;
        do_frame("post_reset", 8'h9F, 8, 24, 8'h00, 1, 8'h9F, 1'b1);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] c, st;
            int nc, nr;
            bit full;
            case ($urandom_range(0, 3))
                0: c = 8'h9F;
                1: c = 8'h05;
                default: c = 8'($urandom);
            endcase
            nc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
            full = (nc == 8);
            nr = full ? int'($urandom_range(0, 40)) : 0;
            st = 8'($urandom);
            do_frame($sformatf("rand%0d", r), c, nc, nr, st, full ? 1 : 0,
                     full ? c : last_byte, full && talks(c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
